// File: rtl/pipeline_result_collector_if.sv
// Result stream into the collector and the valid/ready stream out of it.
// The master modport is the producer/consumer side; the slave modport is the collector.
interface pipeline_result_collector_if #(
  parameter int DATA_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/pipeline_result_collector.sv
// FWFT FIFO capturing pipeline results with drop counting; optional running
// checksum of accepted words when COLLECTOR_CHECKSUM_EN is defined.
module pipeline_result_collector #(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          pon_rst_n_i,
  pipeline_result_collector_if.slave    bus,
  input  logic                          clear_stats,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          drop_count
`ifdef COLLECTOR_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]         checksum
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign bus.out_valid = (fifo_level != '0);
  assign bus.out_data  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  always_comb begin
    pop  = bus.out_valid & bus.out_ready;
    push = bus.in_valid & ((fifo_level != LW'(FIFO_DEPTH)) | pop);
    drop = bus.in_valid & ~push;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Clear takes effect first, then a same-cycle drop is counted on top.
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_stats) begin
      overflow   <= drop;
      drop_count <= drop ? CNT_WIDTH'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

`ifdef COLLECTOR_CHECKSUM_EN
  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      checksum <= '0;
    end else if (clear_stats) begin
      checksum <= push ? bus.in_data : '0;
    end else if (push) begin
      checksum <= checksum + bus.in_data;
    end
  end
`endif

endmodule
